// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Multi-cycle control sequencer sitting between the instruction decoder and
//   the ALU / register file / memory bus. Accepts one decoded 8-bit opcode per
//   handshake, fetches the operand (register file, accumulator, (HL) or an
//   immediate byte), drives the ALU control inputs for one EXEC cycle, and
//   writes the result back to A, a register-file entry or memory.
//
// Ports
//   i_Clk, i_Reset         clock, synchronous active-high reset
//   i_Enable               clock enable; state frozen and commit strobes gated when low
//   i_Valid/o_Ready        opcode handshake (o_Ready high only in IDLE)
//   i_Opcode               opcode to execute
//   o_Done/o_Illegal       registered completion / illegal-opcode pulses
//   o_Reg_*/i_Reg_Data     register-file select, read data, write strobe and data
//   o_Mem_*/i_Mem_*        memory request/handshake; address select 0=HL, 1=PC
//   o_PC_Inc               PC increment strobe after the immediate fetch
//   o_ALU_*/i_ALU_*        ALU opcode, operand, unit select, flag save,
//                          accumulator read/write and result feedback
module alu_op_sequencer #(
    parameter bit ENABLE_MISC = 1'b1
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Enable,
    input  logic       i_Valid,
    output logic       o_Ready,
    input  logic [7:0] i_Opcode,
    output logic       o_Done,
    output logic       o_Illegal,
    output logic [2:0] o_Reg_Sel,
    input  logic [7:0] i_Reg_Data,
    output logic       o_Reg_Write,
    output logic [7:0] o_Reg_Wdata,
    output logic       o_Mem_Req,
    output logic       o_Mem_Write,
    output logic       o_Mem_Addr_Sel,
    output logic [7:0] o_Mem_Wdata,
    input  logic [7:0] i_Mem_Rdata,
    input  logic       i_Mem_Ack,
    output logic       o_PC_Inc,
    output logic [7:0] o_ALU_Opcode,
    output logic [7:0] o_ALU_Parameter,
    output logic [5:0] o_ALU_Function_Control,
    output logic       o_ALU_Save_Flags,
    output logic [1:0] o_ALU_Read,
    output logic [1:0] o_ALU_Write,
    output logic [7:0] o_ALU_Data,
    input  logic [7:0] i_ALU_Result,
    input  logic [7:0] i_ALU_Reg_Data
);

    typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_EXEC, S_MEM_WRITE} state_e;
    typedef enum logic [2:0] {C_ILLEGAL, C_ALU, C_IMM, C_INC, C_DEC, C_MISC} class_e;

    function automatic class_e classify(input logic [7:0] op);
        class_e c;
        c = C_ILLEGAL;
        if (op[7:6] == 2'b10)                           c = C_ALU;
        else if (op[7:6] == 2'b11 && op[2:0] == 3'b110) c = C_IMM;
        else if (op[7:6] == 2'b00 && op[2:0] == 3'b100) c = C_INC;
        else if (op[7:6] == 2'b00 && op[2:0] == 3'b101) c = C_DEC;
        else if (ENABLE_MISC && (op == 8'h27 || op == 8'h2F ||
                                 op == 8'h37 || op == 8'h3F)) c = C_MISC;
        return c;
    endfunction

    // ALU forms carry the source in [2:0], INC/DEC in [5:3]; the immediate
    // form always has 110 in [2:0], so it shares the memory-source test.
    function automatic logic [2:0] src_idx(input logic [7:0] op);
        return op[7] ? op[2:0] : op[5:3];
    endfunction

    function automatic logic uses_mem(input logic [7:0] op, input class_e c);
        return (c != C_ILLEGAL) && (c != C_MISC) && (src_idx(op) == 3'd6);
    endfunction

    state_e     state_q, state_d;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] operand_q, operand_d;
    logic [7:0] result_q, result_d;
    logic       done_q, done_d;
    logic       illegal_q, illegal_d;

    class_e     in_cls, cur_cls;
    logic [2:0] cur_idx;
    logic       cur_mem, in_mem;
    logic       is_incdec, wr_a, wr_r, wr_m;

    assign in_cls    = classify(i_Opcode);
    assign in_mem    = uses_mem(i_Opcode, in_cls);
    assign cur_cls   = classify(opcode_q);
    assign cur_idx   = src_idx(opcode_q);
    assign cur_mem   = uses_mem(opcode_q, cur_cls);
    assign is_incdec = (cur_cls == C_INC) || (cur_cls == C_DEC);
    assign wr_a      = (((cur_cls == C_ALU) || (cur_cls == C_IMM)) && (opcode_q[5:3] != 3'b111))
                     || (cur_cls == C_MISC) || (is_incdec && cur_idx == 3'd7);
    assign wr_r      = is_incdec && (cur_idx < 3'd6);
    assign wr_m      = is_incdec && (cur_idx == 3'd6);

    assign o_Ready      = (state_q == S_IDLE);
    assign o_Done       = done_q;
    assign o_Illegal    = illegal_q;
    assign o_ALU_Opcode = opcode_q;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            operand_q <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            result_q  <= result_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        result_d  = result_q;
        done_d    = done_q;
        illegal_d = illegal_q;

        o_Reg_Sel              = '0;
        o_Reg_Write            = 1'b0;
        o_Reg_Wdata            = '0;
        o_Mem_Req              = 1'b0;
        o_Mem_Write            = 1'b0;
        o_Mem_Addr_Sel         = 1'b0;
        o_Mem_Wdata            = '0;
        o_PC_Inc               = 1'b0;
        o_ALU_Parameter        = '0;
        o_ALU_Function_Control = '0;
        o_ALU_Save_Flags       = 1'b0;
        o_ALU_Read             = '0;
        o_ALU_Write            = '0;
        o_ALU_Data             = '0;

        // Pulses clear every enabled cycle and hold while the enable is low.
        if (i_Enable) begin
            done_d    = 1'b0;
            illegal_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (i_Valid && i_Enable) begin
                    if (in_cls == C_ILLEGAL) begin
                        done_d    = 1'b1;
                        illegal_d = 1'b1;
                    end else begin
                        opcode_d = i_Opcode;
                        state_d  = in_mem ? S_MEM_READ : S_EXEC;
                    end
                end
            end

            S_MEM_READ: begin
                o_Mem_Req      = 1'b1;
                o_Mem_Addr_Sel = (cur_cls == C_IMM);
                if (i_Enable && i_Mem_Ack) begin
                    operand_d = i_Mem_Rdata;
                    o_PC_Inc  = (cur_cls == C_IMM);
                    state_d   = S_EXEC;
                end
            end

            S_EXEC: begin
                case (cur_cls)
                    C_ALU, C_IMM: o_ALU_Function_Control = 6'b000001;
                    C_INC:        o_ALU_Function_Control = 6'b000010;
                    C_DEC:        o_ALU_Function_Control = 6'b000110;
                    C_MISC:       o_ALU_Function_Control = 6'b100000;
                    default:      o_ALU_Function_Control = '0;
                endcase

                if (cur_cls == C_MISC) begin
                    o_ALU_Parameter = '0;
                end else if (cur_mem) begin
                    o_ALU_Parameter = operand_q;
                end else if (cur_idx == 3'd7) begin
                    o_ALU_Read      = 2'b01;
                    o_ALU_Parameter = i_ALU_Reg_Data;
                end else begin
                    o_Reg_Sel       = cur_idx;
                    o_ALU_Parameter = i_Reg_Data;
                end

                if (wr_a) o_ALU_Data  = i_ALU_Result;
                if (wr_r) o_Reg_Wdata = i_ALU_Result;

                if (i_Enable) begin
                    o_ALU_Save_Flags = 1'b1;
                    if (wr_a) o_ALU_Write = 2'b01;
                    if (wr_r) o_Reg_Write = 1'b1;
                    if (wr_m) begin
                        result_d = i_ALU_Result;
                        state_d  = S_MEM_WRITE;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_MEM_WRITE: begin
                o_Mem_Req   = 1'b1;
                o_Mem_Write = 1'b1;
                o_Mem_Wdata = result_q;
                if (i_Enable && i_Mem_Ack) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule
